// File: rtl/fence_t_sequencer_pkg.sv
// Shared types and defaults for the temporal-fence (fence.t) sequencer.
//   fence_t_state_e   : sequencer FSM encoding (3 bits, so illegal codes exist
//                       and are folded back to IDLE by the FSM).
//   FENCE_T_*         : default drain / microreset lengths and address width.
//   cnt_width()       : bit width needed to hold 0..max_val (never 0 bits).
package fence_t_sequencer_pkg;

  // Default address width; matches the core's virtual address width.
  localparam int unsigned FENCE_T_VLEN      = 64;
  localparam int unsigned FENCE_T_DRAIN_CYC = 16;
  localparam int unsigned FENCE_T_RST_CYC   = 16;

  typedef enum logic [2:0] {
    FT_IDLE      = 3'd0,
    FT_FLUSH     = 3'd1,
    FT_DRAIN     = 3'd2,
    FT_PAD       = 3'd3,
    FT_RST_UARCH = 3'd4
  } fence_t_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fence_t_sequencer_cnt.sv
// Generic up/down counter shared by the sequencer's pad and drain timers.
// Priority: clear > load > increment (saturating at MAX) > decrement (stops at 0).
//   clk_i, rst_i : clock, synchronous active-high reset (count -> 0)
//   clear_i      : force count to 0
//   load_i       : load load_val_i
//   load_val_i   : value taken on load
//   inc_i        : count up, holding at MAX
//   dec_i        : count down, holding at 0
//   cnt_o        : current count
module fence_t_sequencer_cnt #(
  parameter int unsigned    W   = 8,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fence_t_sequencer.sv
// Temporal-fence sequencer: on a committed fence.t it flushes every channel,
// waits for the memory side to drain, pads out to a selectable timing event,
// then pulses a microarchitectural reset and hands back the resume PC.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   fence_t_i       : fence.t committed (accepted only in IDLE)
//   pc_commit_i     : PC of the fence.t; resume at pc+4
//   boot_addr_i     : resume address after a reset
//   rst_addr_o      : PC to fetch from after the microreset
//   flush_o         : per-channel flush request (registered)
//   flush_ack_i     : per-channel flush-done pulse
//   busy_i          : per-channel outstanding-transaction flag
//   pad_i           : pad length in cycles
//   pad_sel_i       : selects which event source starts the pad
//   pad_evt_i       : level event sources, rising edge triggers
//   ceil_o          : measured pad ceiling, ceil_valid_o pulses on update
//   pad_overrun_o   : sticky, pad had already expired when draining finished
//   halt_o, stall_o : sequence in progress (commit halt / cache stall)
//   rst_uarch_no    : active-low microreset, RST_CYC cycles long
//   cache_init_no   : suppress cache init through the microreset and INIT_HOLD after
module fence_t_sequencer
  import fence_t_sequencer_pkg::*;
#(
  parameter int unsigned NR_CHAN    = 2,
  parameter int unsigned NR_PAD_SRC = 2,
  parameter int unsigned PAD_W      = 32,
  parameter int unsigned DRAIN_CYC  = FENCE_T_DRAIN_CYC,
  parameter int unsigned RST_CYC    = FENCE_T_RST_CYC,
  parameter int unsigned INIT_HOLD  = 3,
  parameter int unsigned VLEN       = FENCE_T_VLEN
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          fence_t_i,
  input  logic [VLEN-1:0]               pc_commit_i,
  input  logic [VLEN-1:0]               boot_addr_i,
  output logic [VLEN-1:0]               rst_addr_o,
  output logic [NR_CHAN-1:0]            flush_o,
  input  logic [NR_CHAN-1:0]            flush_ack_i,
  input  logic [NR_CHAN-1:0]            busy_i,
  input  logic [PAD_W-1:0]              pad_i,
  input  logic [$clog2(NR_PAD_SRC)-1:0] pad_sel_i,
  input  logic [NR_PAD_SRC-1:0]         pad_evt_i,
  output logic [PAD_W-1:0]              ceil_o,
  output logic                          ceil_valid_o,
  output logic                          pad_overrun_o,
  output logic                          halt_o,
  output logic                          stall_o,
  output logic                          rst_uarch_no,
  output logic                          cache_init_no
);

  localparam int unsigned SEL_W   = $clog2(NR_PAD_SRC);
  localparam int unsigned DRAIN_W = cnt_width(DRAIN_CYC);
  localparam int unsigned RST_W   = cnt_width(RST_CYC - 1);
  localparam int unsigned INIT_W  = cnt_width(INIT_HOLD);

  fence_t_state_e state_q, state_d;

  logic [NR_CHAN-1:0]    ack_seen_q, ack_seen_d;
  logic [NR_CHAN-1:0]    flush_q, flush_d;
  logic [VLEN-1:0]       rst_addr_q, rst_addr_d;
  logic [PAD_W-1:0]      ceil_q, ceil_d;
  logic                  ceil_valid_q, ceil_valid_d;
  logic                  overrun_q, overrun_d;
  logic [NR_PAD_SRC-1:0] evt_q, evt_d;
  logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [INIT_W-1:0]     init_cnt_q, init_cnt_d;

  logic [PAD_W-1:0]      pad_cnt;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic                  pad_load;
  logic                  acks_done, drain_done, pad_done, rst_done;

  // ---------------------------------------------------------------------------
  // Timers. Both run regardless of FSM state so the pad can start before the
  // fence commits and the drain window can already be satisfied on entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    pad_load = 1'b0;
    // Out-of-range selects match no source, so they never load.
    for (int unsigned i = 0; i < NR_PAD_SRC; i++) begin
      if (pad_sel_i == SEL_W'(i)) begin
        pad_load = pad_evt_i[i] & ~evt_q[i];
      end
    end
  end

  fence_t_sequencer_cnt #(
    .W   (PAD_W),
    .MAX ('1)
  ) i_pad_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (1'b0),
    .load_i     (pad_load),
    .load_val_i (pad_i),
    .inc_i      (1'b0),
    .dec_i      (1'b1),
    .cnt_o      (pad_cnt)
  );

  fence_t_sequencer_cnt #(
    .W   (DRAIN_W),
    .MAX (DRAIN_W'(DRAIN_CYC))
  ) i_drain_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (|busy_i),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (1'b1),
    .dec_i      (1'b0),
    .cnt_o      (drain_cnt)
  );

  // Acks landing this cycle count, so the last ack and FLUSH exit coincide.
  assign acks_done  = &(ack_seen_q | flush_ack_i);
  assign drain_done = (drain_cnt == DRAIN_W'(DRAIN_CYC));
  assign pad_done   = (pad_cnt == '0);
  assign rst_done   = (rst_cnt_q == RST_W'(RST_CYC - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      FT_IDLE:      if (fence_t_i)  state_d = FT_FLUSH;
      FT_FLUSH:     if (acks_done)  state_d = FT_DRAIN;
      FT_DRAIN:     if (drain_done) state_d = FT_PAD;
      FT_PAD:       if (pad_done)   state_d = FT_RST_UARCH;
      FT_RST_UARCH: if (rst_done)   state_d = FT_IDLE;
      default:                      state_d = FT_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    halt_o        = (state_q != FT_IDLE);
    stall_o       = (state_q != FT_IDLE);
    rst_uarch_no  = (state_q != FT_RST_UARCH);
    cache_init_no = (state_q == FT_RST_UARCH) || (init_cnt_q != '0);
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    ack_seen_d   = ack_seen_q;
    flush_d      = '0;
    rst_addr_d   = rst_addr_q;
    ceil_d       = ceil_q;
    ceil_valid_d = 1'b0;
    overrun_d    = overrun_q;
    evt_d        = pad_evt_i;
    rst_cnt_d    = '0;
    init_cnt_d   = (init_cnt_q != '0) ? init_cnt_q - INIT_W'(1) : init_cnt_q;

    case (state_q)
      FT_IDLE: begin
        ack_seen_d = '0;
        // Per-fence results change only when a new fence is accepted, so the
        // overrun flag and resume PC of the last sequence stay readable.
        if (fence_t_i) begin
          rst_addr_d = pc_commit_i + VLEN'(4);
          overrun_d  = 1'b0;
        end
      end
      FT_FLUSH: begin
        ack_seen_d = ack_seen_q | flush_ack_i;
        // Registered request: a channel drops the cycle after its ack.
        flush_d    = ~(ack_seen_q | flush_ack_i);
      end
      FT_DRAIN: begin
        if (drain_done) begin
          ceil_d       = pad_done ? '0 : pad_i - pad_cnt;
          ceil_valid_d = 1'b1;
          overrun_d    = pad_done;
        end
      end
      FT_RST_UARCH: begin
        rst_cnt_d  = rst_done ? '0 : rst_cnt_q + RST_W'(1);
        init_cnt_d = INIT_W'(INIT_HOLD);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_seen_q   <= '0;
      flush_q      <= '0;
      rst_addr_q   <= boot_addr_i;
      ceil_q       <= '0;
      ceil_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      evt_q        <= '0;
      rst_cnt_q    <= '0;
      init_cnt_q   <= '0;
    end else begin
      ack_seen_q   <= ack_seen_d;
      flush_q      <= flush_d;
      rst_addr_q   <= rst_addr_d;
      ceil_q       <= ceil_d;
      ceil_valid_q <= ceil_valid_d;
      overrun_q    <= overrun_d;
      evt_q        <= evt_d;
      rst_cnt_q    <= rst_cnt_d;
      init_cnt_q   <= init_cnt_d;
    end
  end

  assign rst_addr_o    = rst_addr_q;
  assign flush_o       = flush_q;
  assign ceil_o        = ceil_q;
  assign ceil_valid_o  = ceil_valid_q;
  assign pad_overrun_o = overrun_q;

endmodule
